cr_kme_fifo_param: RTL and testbench
====================================

# cr_kme_fifo_param

Parametrised first-word-fall-through FIFO for KME datapath buffering; successor of the fixed 4-bit, 4-entry KME FIFO. Adds configurable width and depth (non-power-of-two allowed), a programmable early-stall threshold, occupancy outputs, synchronous flush, and explicit underflow detection on ack-while-empty. Sits between a producer that honours `fifo_in_stall` and a consumer using a valid/ack pull interface.

## Interface
- `WIDTH`, default 4: data width in bits, ≥1.
- `DEPTH`, default 4: number of entries, ≥2; need not be a power of two.
- `STALL_THRESH`, default 0: `fifo_in_stall` asserts while free slots ≤ `STALL_THRESH`; range 0..`DEPTH`-1.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fifo_in` in `WIDTH`: write data.
- `fifo_in_valid` in 1: write request; sampled every cycle, regardless of stall.
- `fifo_in_stall_override` in 1: forces `fifo_in_stall` high.
- `fifo_clear` in 1: synchronous flush.
- `fifo_out_ack` in 1: consumer pops the head entry.
- `fifo_in_stall` out 1: back-pressure to the producer.
- `fifo_out` out `WIDTH`: head entry; meaningful only while `fifo_out_valid`=1.
- `fifo_out_valid` out 1: FIFO is non-empty.
- `fifo_used_slots` out `CW`: occupancy. `CW` = $clog2(`DEPTH`+1).
- `fifo_free_slots` out `CW`: `DEPTH` − occupancy.
- `fifo_overflow` out 1: write was dropped because the FIFO was full.
- `fifo_underflow` out 1: ack was received while the FIFO was empty.

## Operation
- State: write pointer, read pointer, `CW`-bit count, and a `DEPTH`×`WIDTH` storage array. Storage is not reset.
- Pointers run 0..`DEPTH`-1 and wrap from `DEPTH`-1 to 0; there is no power-of-two masking.
- `ren` = `fifo_out_ack` & `fifo_out_valid`.
- `wen` = `fifo_in_valid` & (count < `DEPTH` | `ren`).
  - A write to a full FIFO in the same cycle as a pop is accepted; count is unchanged.
- Count update: +1 on `wen` only; −1 on `ren` only; unchanged when both or neither occur.
- Overflow event: `fifo_in_valid` & full & !`ren`. The data is dropped and no state changes.
- Underflow event: `fifo_out_ack` & empty. The ack is ignored.
- `fifo_out` = storage[read pointer], combinational. A write to an empty FIFO is visible on `fifo_out` the next cycle.
- `fifo_in_stall` = (`fifo_free_slots` ≤ `STALL_THRESH`) | `fifo_in_stall_override`, combinational from registered count.
- `fifo_clear`:
  - Next cycle: pointers and count are 0.
  - `wen`, `ren`, and error detection are all suppressed in the clear cycle.
  - Takes precedence over every other input except `rst`.
- `rst`: same effect as `fifo_clear`, and also clears the error flags.
  - Reset applied mid-operation discards all contents.
  - Reset values: `fifo_out_valid`=0, `fifo_used_slots`=0, `fifo_free_slots`=`DEPTH`, `fifo_overflow`=0, `fifo_underflow`=0.
  - `fifo_in_stall` = `fifo_in_stall_override` | (`DEPTH` ≤ `STALL_THRESH`).
  - `fifo_out` is don't-care.

## Timing
- Write-to-read latency: 1 cycle. Data written in cycle N appears on `fifo_out` with `fifo_out_valid`=1 in cycle N+1.
- `fifo_used_slots`, `fifo_free_slots`, `fifo_out_valid`, and `fifo_in_stall` all reflect the updates from cycle N in cycle N+1.
- `fifo_overflow` and `fifo_underflow` are registered. An event in cycle N produces a one-cycle pulse in N+1.
  - Back-to-back events give back-to-back pulses.
- Pop is zero-latency: `fifo_out_ack` in cycle N removes the head at the N→N+1 edge.
- Sustained full-rate write+pop at any occupancy gives 1 entry per cycle throughput.

## Configuration
- `CR_KME_FIFO_STICKY_ERR_EN` defined:
  - `fifo_overflow` and `fifo_underflow` become sticky.
  - Each sets on its event (visible N+1) and holds until `fifo_clear` or `rst`.
  - Clear wins over a same-cycle event.
- Undefined: both flags are single-cycle pulses as described in Timing.

## Test plan
- `DEPTH`=5, `WIDTH`=8: write 0x11..0x15 on consecutive cycles, then ack 5 cycles.
  - Data pops in order.
  - Used slots go 0→5→0.
  - Pointers wrap correctly on the next 5 writes.
- Full `DEPTH`=5, write 0xAA without ack → `fifo_overflow` pulses one cycle, count stays 5, 0xAA never read.
- Full `DEPTH`=5, write 0xBB with simultaneous ack → no overflow, count stays 5, 0xBB read last.
- `STALL_THRESH`=2, `DEPTH`=5: after 3 writes, stall rises the next cycle. `fifo_in_stall_override`=1 on an empty FIFO → stall=1.
- Ack on empty → `fifo_underflow` pulses, count stays 0.
  - With `CR_KME_FIFO_STICKY_ERR_EN`, the flag holds until `fifo_clear`, then drops the following cycle.
- 3 entries, `fifo_clear` with a concurrent write and ack → next cycle count=0 and valid=0, with no error flag. Then assert `rst` mid-stream → all outputs return to reset values.

Source files
------------

// File: rtl/cr_kme_fifo_param.sv
// cr_kme_fifo_param
// Parametrised first-word-fall-through FIFO for KME datapath buffering.
// The head entry is presented combinationally on fifo_out whenever the FIFO
// holds data; the consumer pulls it with fifo_out_ack. Depth need not be a
// power of two; pointers wrap explicitly at DEPTH-1.
//
// Optional feature macro: CR_KME_FIFO_STICKY_ERR_EN
//   defined   -> fifo_overflow / fifo_underflow hold until fifo_clear or rst
//   undefined -> both flags are one-cycle pulses
//
// Parameters:
//   WIDTH         data width in bits (>=1)
//   DEPTH         number of entries (>=2)
//   STALL_THRESH  stall asserts while free slots <= this value (0..DEPTH-1)
//
// Ports:
//   clk                     rising-edge clock
//   rst                     synchronous active-high reset
//   fifo_in                 write data
//   fifo_in_valid           write request
//   fifo_in_stall_override  forces fifo_in_stall high
//   fifo_clear              synchronous flush
//   fifo_out_ack            consumer pops the head entry
//   fifo_in_stall           back-pressure to producer
//   fifo_out                head entry (valid while fifo_out_valid)
//   fifo_out_valid          FIFO non-empty
//   fifo_used_slots         occupancy
//   fifo_free_slots         DEPTH - occupancy
//   fifo_overflow           write dropped because FIFO was full
//   fifo_underflow          ack received while FIFO was empty
module cr_kme_fifo_param #(
  parameter int WIDTH        = 4,
  parameter int DEPTH        = 4,
  parameter int STALL_THRESH = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             fifo_in,
  input  logic                         fifo_in_valid,
  input  logic                         fifo_in_stall_override,
  input  logic                         fifo_clear,
  input  logic                         fifo_out_ack,
  output logic                         fifo_in_stall,
  output logic [WIDTH-1:0]             fifo_out,
  output logic                         fifo_out_valid,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_used_slots,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_free_slots,
  output logic                         fifo_overflow,
  output logic                         fifo_underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(STALL_THRESH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic full;
  logic empty;
  logic flush;
  logic ren;
  logic wen;
  logic ovf_evt;
  logic unf_evt;

  // Pointers wrap at DEPTH-1 rather than by masking, so any depth works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Reset and clear both suppress every read, write and error event.
  assign flush   = rst | fifo_clear;
  assign ren     = fifo_out_ack & ~empty & ~flush;
  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign wen     = fifo_in_valid & (~full | ren) & ~flush;
  assign ovf_evt = fifo_in_valid & full & ~ren & ~flush;
  assign unf_evt = fifo_out_ack & empty & ~flush;

  // Storage has no reset; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[wr_ptr] <= fifo_in;
    end
  end

  // Pointer, occupancy and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else if (fifo_clear) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      if (wen) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (ren) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wen, ren})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
`ifdef CR_KME_FIFO_STICKY_ERR_EN
      fifo_overflow  <= fifo_overflow  | ovf_evt;
      fifo_underflow <= fifo_underflow | unf_evt;
`else
      fifo_overflow  <= ovf_evt;
      fifo_underflow <= unf_evt;
`endif
    end
  end

  assign fifo_out        = mem[rd_ptr];
  assign fifo_out_valid  = ~empty;
  assign fifo_used_slots = count;
  assign fifo_free_slots = DEPTH_C - count;
  assign fifo_in_stall   = (fifo_free_slots <= THRESH_C) | fifo_in_stall_override;

endmodule

// File: tb/tb_cr_kme_fifo_param.sv
// tb_cr_kme_fifo_param
// Bench for cr_kme_fifo_param with DEPTH=5, WIDTH=8, STALL_THRESH=2.
// The reference model is a data queue plus an occupancy count and flag
// state; accepted writes are pushed into the scoreboard queue, and a monitor
// on the falling edge compares the presented head entry and pops it on ack.
module tb_cr_kme_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int THR   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] fifo_in = '0;
  logic             fifo_in_valid = 1'b0;
  logic             fifo_in_stall_override = 1'b0;
  logic             fifo_clear = 1'b0;
  logic             fifo_out_ack = 1'b0;
  logic             fifo_in_stall;
  logic [WIDTH-1:0] fifo_out;
  logic             fifo_out_valid;
  logic [CW-1:0]    fifo_used_slots;
  logic [CW-1:0]    fifo_free_slots;
  logic             fifo_overflow;
  logic             fifo_underflow;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb_q[$];
  int               m_cnt = 0;
  bit               m_ovf = 0;
  bit               m_unf = 0;

  cr_kme_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_THRESH(THR)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .fifo_in                (fifo_in),
    .fifo_in_valid          (fifo_in_valid),
    .fifo_in_stall_override (fifo_in_stall_override),
    .fifo_clear             (fifo_clear),
    .fifo_out_ack           (fifo_out_ack),
    .fifo_in_stall          (fifo_in_stall),
    .fifo_out               (fifo_out),
    .fifo_out_valid         (fifo_out_valid),
    .fifo_used_slots        (fifo_used_slots),
    .fifo_free_slots        (fifo_free_slots),
    .fifo_overflow          (fifo_overflow),
    .fifo_underflow         (fifo_underflow)
  );

  always #5 clk = ~clk;

  // Compare one value and report a failure line if it differs.
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT presents data, it must match the oldest
  // accepted write; an ack outside flush cycles consumes that entry.
  always @(negedge clk) begin
    if (!rst && !$isunknown(fifo_out_valid) && fifo_out_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL head_data: valid with empty scoreboard, got 0x%02h", fifo_out);
      end else begin
        check("head_data", int'(fifo_out), int'(sb_q[0]));
        if (fifo_out_ack && !fifo_clear) begin
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // Compare all status outputs against the model after an edge.
  task automatic checkOutput();
    bit exp_stall;
    exp_stall = ((DEPTH - m_cnt) <= THR) || fifo_in_stall_override;
    check("used_slots", int'(fifo_used_slots), m_cnt);
    check("free_slots", int'(fifo_free_slots), DEPTH - m_cnt);
    check("out_valid",  int'(fifo_out_valid),  int'(m_cnt > 0));
    check("in_stall",   int'(fifo_in_stall),   int'(exp_stall));
    check("overflow",   int'(fifo_overflow),   int'(m_ovf));
    check("underflow",  int'(fifo_underflow),  int'(m_unf));
  endtask

  // Drive one cycle of inputs, advance the model by that cycle, then check.
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input bit wv, input bit ack,
                               input bit clr, input bit ovr, input bit rs);
    bit pop, push, ovf_e, unf_e;
    fifo_in                = d;
    fifo_in_valid          = wv;
    fifo_out_ack           = ack;
    fifo_clear             = clr;
    fifo_in_stall_override = ovr;
    rst                    = rs;
    if (rs || clr) begin
      m_cnt = 0;
      m_ovf = 0;
      m_unf = 0;
      @(posedge clk);
      sb_q.delete();
    end else begin
      pop   = ack && (m_cnt > 0);
      push  = wv && ((m_cnt < DEPTH) || pop);
      ovf_e = wv && (m_cnt == DEPTH) && !pop;
      unf_e = ack && (m_cnt == 0);
      m_cnt = m_cnt + int'(push) - int'(pop);
`ifdef CR_KME_FIFO_STICKY_ERR_EN
      m_ovf = m_ovf || ovf_e;
      m_unf = m_unf || unf_e;
`else
      m_ovf = ovf_e;
      m_unf = unf_e;
`endif
      @(posedge clk);
      if (push) sb_q.push_back(d);
    end
    #1;
    checkOutput();
  endtask

  initial begin
    // Reset state
    applyStimulus(8'h00, 0, 0, 0, 0, 1);
    applyStimulus(8'h00, 0, 0, 0, 0, 1);
    applyStimulus(8'h00, 0, 0, 0, 0, 0);

    // Fill with 0x11..0x15, drain, then repeat to exercise pointer wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) applyStimulus(8'(8'h11 + 8'(i) + 8'(r * 16)), 1, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) applyStimulus(8'h00, 0, 1, 0, 0, 0);
    end

    // Overflow on full, then write with simultaneous pop at full
    for (int i = 0; i < DEPTH; i++) applyStimulus(8'(8'h21 + 8'(i)), 1, 0, 0, 0, 0);
    applyStimulus(8'hAA, 1, 0, 0, 0, 0);
    applyStimulus(8'hAA, 1, 0, 0, 0, 0);
    applyStimulus(8'hBB, 1, 1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(8'h00, 0, 1, 0, 0, 0);

    // Stall override on empty FIFO, then underflow
    applyStimulus(8'h00, 0, 0, 0, 1, 0);
    applyStimulus(8'h00, 0, 1, 0, 0, 0);
    applyStimulus(8'h00, 0, 1, 0, 0, 0);
    applyStimulus(8'h00, 0, 0, 0, 0, 0);
    applyStimulus(8'h00, 0, 0, 1, 0, 0);
    applyStimulus(8'h00, 0, 0, 0, 0, 0);

    // Clear with concurrent write and ack on 3 entries
    for (int i = 0; i < 3; i++) applyStimulus(8'(8'h31 + 8'(i)), 1, 0, 0, 0, 0);
    applyStimulus(8'h3F, 1, 1, 1, 0, 0);
    applyStimulus(8'h00, 0, 0, 0, 0, 0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) applyStimulus(8'(8'h41 + 8'(i)), 1, 0, 0, 0, 0);
    applyStimulus(8'h4F, 1, 1, 0, 0, 1);
    applyStimulus(8'h00, 0, 0, 0, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(8'($urandom), ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50),
                    ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 127) == 0));
    end

    // Drain remaining entries
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(8'h00, 0, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
